// File: rtl/ltl_mon_pkg.sv
// Shared types and constants for the LTL cluster reporter.
// Provides the id-width helper, default parameters and the event record layout.
package ltl_mon_pkg;

  localparam int DEF_SYM_W       = 8;
  localparam int DEF_NUM_LTL     = 13;
  localparam int DEF_RPT_PER_LTL = 4;
  localparam int DEF_STAMP_W     = 16;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_CNT_W       = 8;

  // $clog2 that never returns 0, so a single property still gets a 1-bit id
  function automatic int LTL_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = LTL_ID_W(DEF_NUM_LTL);

  typedef struct packed {
    logic [DEF_ID_W-1:0]    id;
    logic [DEF_STAMP_W-1:0] stamp;
  } evt_rec_t;

endpackage

// File: rtl/ltl_evt_fifo.sv
// Synchronous FIFO with registered head record, full/empty flags and count.
// Ports: clk_i/rst_i, wr_en_i/wr_data_i, rd_en_i, head_valid_o/head_data_o,
// full_o, empty_o, count_o.
module ltl_evt_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic                     head_valid_o,
  output logic [W-1:0]             head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          head_valid_q, head_valid_d;
  logic [W-1:0]  head_data_q, head_data_d;
  logic          wr_ok, rd_ok;

  // full is judged on the current count: no write lands on a full FIFO
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr_ok   = wr_en_i & ~full_o;
  assign rd_ok   = rd_en_i & head_valid_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d     = rd_ptr_q + AW'(rd_ok);
    count_d      = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    head_valid_d = (count_d != '0);
    // the slot being written may become the new head this very edge
    if (wr_ok && (wr_ptr_q == rd_ptr_d))
      head_data_d = wr_data_i;
    else
      head_data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok)
      mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_data_q;

endmodule

// File: rtl/ltl_cluster_reporter.sv
// Per-cluster LTL match merger with sticky flags, timestamps and an event queue.
// Ports: report_in -> ltl_out/ltl_sticky, evt_* valid/ready record stream,
// overflow, cnt_sel/cnt_data. Macro LTL_HIT_COUNT_EN adds hit counters.
module ltl_cluster_reporter
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W       = DEF_SYM_W,
  parameter int NUM_LTL     = DEF_NUM_LTL,
  parameter int RPT_PER_LTL = DEF_RPT_PER_LTL,
  parameter int STAMP_W     = DEF_STAMP_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run,
  input  logic [SYM_W-1:0]                 symbols,
  input  logic [NUM_LTL*RPT_PER_LTL-1:0]   report_in,
  input  logic                             clear_sticky,
  output logic [NUM_LTL-1:0]               ltl_out,
  output logic [NUM_LTL-1:0]               ltl_sticky,
  output logic                             evt_valid,
  input  logic                             evt_ready,
  output logic [LTL_ID_W(NUM_LTL)-1:0]     evt_ltl_id,
  output logic [STAMP_W-1:0]               evt_stamp,
  output logic                             overflow,
  input  logic [LTL_ID_W(NUM_LTL)-1:0]     cnt_sel,
  output logic [CNT_W-1:0]                 cnt_data
);

  localparam int ID_W  = LTL_ID_W(NUM_LTL);
  localparam int REC_W = ID_W + STAMP_W;

  logic [NUM_LTL-1:0] hit;
  logic [NUM_LTL-1:0] pend_q, pend_d;
  logic [NUM_LTL-1:0] new_hit, coal, enq_oh;
  logic [NUM_LTL-1:0] sticky_q, sticky_d;
  logic               overflow_q, overflow_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [STAMP_W-1:0] pstamp_q [NUM_LTL];
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    sel_id;
  logic               sel_found;
  logic               enq;
  logic               fifo_full;
  logic [REC_W-1:0]   head;
  logic               unused_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_cnt;
  logic               unused_ok;
  int                 idx;

  always_comb begin
    ltl_out = '0;
    for (int k = 0; k < NUM_LTL; k++)
      ltl_out[k] = |report_in[k*RPT_PER_LTL +: RPT_PER_LTL];
  end

  assign hit = ltl_out & {NUM_LTL{run}};

  // first pending property at or after rr_q, wrapping at NUM_LTL-1
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_LTL; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_LTL)
        idx = idx - NUM_LTL;
      if (!sel_found && pend_q[idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(idx);
      end
    end
  end

  assign enq = run & sel_found & ~fifo_full;

  always_comb begin
    enq_oh = '0;
    if (enq)
      enq_oh[sel_id] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (enq)
      rr_d = (sel_id == ID_W'(NUM_LTL-1)) ? '0 : sel_id + 1'b1;
  end

  // a hit on the entry leaving this cycle re-arms it with a fresh stamp
  assign new_hit = hit & (~pend_q | enq_oh);
  assign coal    = hit & pend_q & ~enq_oh;
  assign pend_d  = (pend_q & ~enq_oh) | hit;

  assign sticky_d   = clear_sticky ? '0 : (sticky_q | hit);
  assign overflow_d = clear_sticky ? 1'b0 : (overflow_q | (|coal));
  assign stamp_d    = run ? stamp_q + 1'b1 : stamp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      sticky_q   <= '0;
      overflow_q <= 1'b0;
      stamp_q    <= '0;
      rr_q       <= '0;
      for (int k = 0; k < NUM_LTL; k++)
        pstamp_q[k] <= '0;
    end else begin
      pend_q     <= pend_d;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      stamp_q    <= stamp_d;
      rr_q       <= rr_d;
      for (int k = 0; k < NUM_LTL; k++)
        if (new_hit[k])
          pstamp_q[k] <= stamp_q;
    end
  end

  ltl_evt_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (reset),
    .wr_en_i      (enq),
    .wr_data_i    ({sel_id, pstamp_q[sel_id]}),
    .rd_en_i      (evt_ready),
    .head_valid_o (evt_valid),
    .head_data_o  (head),
    .full_o       (fifo_full),
    .empty_o      (unused_empty),
    .count_o      (unused_cnt)
  );

  assign evt_ltl_id = head[REC_W-1 -: ID_W];
  assign evt_stamp  = head[STAMP_W-1:0];
  assign ltl_sticky = sticky_q;
  assign overflow   = overflow_q;

`ifdef LTL_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_LTL];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_LTL; k++)
        cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LTL; k++)
        if (hit[k] && (cnt_q[k] != '1))
          cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  always_comb begin
    cnt_data = '0;
    if (int'(cnt_sel) < NUM_LTL)
      cnt_data = cnt_q[cnt_sel];
  end

  assign unused_ok = ^symbols;
`else
  assign cnt_data  = '0;
  assign unused_ok = ^{symbols, cnt_sel};
`endif

endmodule
